// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and types for the ID/EX pipeline stage: ALU control codes,
// forward-select codes, the stage register layout and its bubble value.
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 5;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD      = 5'd0,
    ALU_SUB      = 5'd1,
    ALU_AND      = 5'd2,
    ALU_OR       = 5'd3,
    ALU_XOR      = 5'd4,
    ALU_NOR      = 5'd5,
    ALU_SLT      = 5'd6,
    ALU_SLTU     = 5'd7,
    ALU_SLL      = 5'd8,
    ALU_SRL      = 5'd9,
    ALU_SRA      = 5'd10,
    ALU_LUI      = 5'd11,
    ALUCTRL_NULL = 5'd31
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [REG_W-1:0]  shamt;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [REG_W-1:0]  rs_addr;
    logic [REG_W-1:0]  rt_addr;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_read;
  } stage_t;

  // A bubble is all-zero except for the ALU control, which carries the NULL op.
  function automatic stage_t stage_bubble();
    stage_t s;
    s          = '0;
    s.alu_ctrl = ALUCTRL_NULL;
    return s;
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Three-way operand select: EX/MEM result, else MEM/WB result, else the
// register-file value captured in the stage. Register 0 is never forwarded.
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [REG_W-1:0]  src_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exmem_wr,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] data
);

  fwd_sel_t sel;

  always_comb begin
    sel = FWD_REG;
    if (src_addr != '0) begin
      if (exmem_wr && (exmem_rd == src_addr)) begin
        sel = FWD_EXMEM;
      end else if (memwb_wr && (memwb_rd == src_addr)) begin
        sel = FWD_MEMWB;
      end
    end
  end

  always_comb begin
    case (sel)
      FWD_EXMEM: data = exmem_data;
      FWD_MEMWB: data = memwb_data;
      default:   data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, load-use hazard detection and
// operand forwarding. Define ID_EX_FORWARDING_EN to enable forwarding.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] IdRsData,
  input  logic [31:0] IdRtData,
  input  logic [31:0] IdImm,
  input  logic        IdUseImm,
  input  logic [4:0]  IdShamt,
  input  logic [4:0]  IdALUCtrl,
  input  logic [4:0]  IdRsAddr,
  input  logic [4:0]  IdRtAddr,
  input  logic [4:0]  IdRdAddr,
  input  logic        IdRegWrite,
  input  logic        IdMemRead,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        ExMemRegWrite,
  input  logic [4:0]  ExMemRd,
  input  logic [31:0] ExMemResult,
  input  logic        MemWbRegWrite,
  input  logic [4:0]  MemWbRd,
  input  logic [31:0] MemWbResult,
  output logic [31:0] ALUIn1,
  output logic [31:0] ALUIn2,
  output logic [4:0]  ALUInShamt,
  output logic [4:0]  ALUCtrl,
  output logic        OutValid,
  output logic [4:0]  OutRd,
  output logic        OutRegWrite,
  output logic        OutMemRead,
  output logic [31:0] OutRtData,
  output logic        HazardStall
);

  stage_t            stage_p1;
  stage_t            id_capture;
  stage_t            stage_next;
  logic              hazard;
  logic              fwd_exmem_wr;
  logic              fwd_memwb_wr;
  logic [DATA_W-1:0] fwd_rs_data;
  logic [DATA_W-1:0] fwd_rt_data;

  always_comb begin
    id_capture           = stage_bubble();
    id_capture.valid     = 1'b1;
    id_capture.rs_data   = IdRsData;
    id_capture.rt_data   = IdRtData;
    id_capture.imm       = IdImm;
    id_capture.use_imm   = IdUseImm;
    id_capture.shamt     = IdShamt;
    id_capture.alu_ctrl  = IdALUCtrl;
    id_capture.rs_addr   = IdRsAddr;
    id_capture.rt_addr   = IdRtAddr;
    id_capture.rd        = IdRdAddr;
    id_capture.reg_write = IdRegWrite;
    id_capture.mem_read  = IdMemRead;
  end

`ifdef ID_EX_FORWARDING_EN
  // With forwarding only a load in the stage forces a bubble; anything else
  // reaches the consumer through the forwarding muxes.
  logic load_in_stage;
  logic rs_hit;
  logic rt_hit;

  always_comb begin
    load_in_stage = stage_p1.valid && stage_p1.mem_read && (stage_p1.rd != '0);
    rs_hit        = (stage_p1.rd == IdRsAddr);
    rt_hit        = (stage_p1.rd == IdRtAddr) && (!IdUseImm || !IdMemRead);
    hazard        = InValid && load_in_stage && (rs_hit || rt_hit);
  end

  assign fwd_exmem_wr = ExMemRegWrite;
  assign fwd_memwb_wr = MemWbRegWrite;
`else
  // Without forwarding, any producer still in flight (this stage or EX/MEM)
  // must retire before a dependent instruction may enter.
  logic stage_hit;
  logic exmem_hit;
  logic unused_memwb_wr;

  always_comb begin
    stage_hit = stage_p1.valid && stage_p1.reg_write && (stage_p1.rd != '0) &&
                ((stage_p1.rd == IdRsAddr) || (stage_p1.rd == IdRtAddr));
    exmem_hit = ExMemRegWrite && (ExMemRd != '0) &&
                ((ExMemRd == IdRsAddr) || (ExMemRd == IdRtAddr));
    hazard    = InValid && (stage_hit || exmem_hit);
  end

  assign fwd_exmem_wr    = 1'b0;
  assign fwd_memwb_wr    = 1'b0;
  assign unused_memwb_wr = MemWbRegWrite;
`endif

  always_comb begin
    if (Flush) begin
      stage_next = stage_bubble();
    end else if (Stall) begin
      stage_next = stage_p1;
    end else if (hazard) begin
      stage_next = stage_bubble();
    end else if (InValid) begin
      stage_next = id_capture;
    end else begin
      stage_next = stage_bubble();
    end
  end

  // ---- ID -> EX stage register (p1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_p1 <= stage_bubble();
    end else begin
      stage_p1 <= stage_next;
    end
  end

  fwd_mux u_fwd_rs (
    .src_addr   (stage_p1.rs_addr),
    .reg_data   (stage_p1.rs_data),
    .exmem_wr   (fwd_exmem_wr),
    .exmem_rd   (ExMemRd),
    .exmem_data (ExMemResult),
    .memwb_wr   (fwd_memwb_wr),
    .memwb_rd   (MemWbRd),
    .memwb_data (MemWbResult),
    .data       (fwd_rs_data)
  );

  fwd_mux u_fwd_rt (
    .src_addr   (stage_p1.rt_addr),
    .reg_data   (stage_p1.rt_data),
    .exmem_wr   (fwd_exmem_wr),
    .exmem_rd   (ExMemRd),
    .exmem_data (ExMemResult),
    .memwb_wr   (fwd_memwb_wr),
    .memwb_rd   (MemWbRd),
    .memwb_data (MemWbResult),
    .data       (fwd_rt_data)
  );

  // ---- EX-side outputs ----
  assign InReady     = !Stall && !hazard && !Flush;
  assign HazardStall = hazard;
  assign ALUIn1      = fwd_rs_data;
  assign ALUIn2      = stage_p1.use_imm ? stage_p1.imm : fwd_rt_data;
  assign OutRtData   = fwd_rt_data;
  assign ALUInShamt  = stage_p1.shamt;
  assign ALUCtrl     = stage_p1.alu_ctrl;
  assign OutValid    = stage_p1.valid;
  assign OutRd       = stage_p1.rd;
  assign OutRegWrite = stage_p1.reg_write;
  assign OutMemRead  = stage_p1.mem_read;

endmodule
